sine_scroll_ctrl: RTL

- Sequencer for the combinational sine layer in the VGA demo.
- Maps the raster position (hpos/vpos) onto the layer's 64x22 cell grid, with integer pixel scaling and a vertical placement window.
- Advances a horizontal scroll phase once per frame and toggles the day/night palette on a frame schedule.
- Registers the resulting pixel colour for the output mux; sits between the VGA timing generator and the top-level RGB output.

---
 rtl/sine_scroll_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sine_scroll_ctrl.sv
// Sequencer for the sine layer: raster-to-cell mapping, per-frame scroll phase,
// day/night palette schedule and the registered output pixel.
module sine_scroll_ctrl #(
    parameter int SCALE_LOG2 = 3,
    parameter int Y_TOP      = 152,
    parameter int DN_FRAMES  = 300
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_display_on,
    input  logic       i_frame_start,
    input  logic       i_pause,
    input  logic       i_step,
    input  logic [1:0] i_speed,
    output logic [5:0] o_sine_x,
    output logic [4:0] o_sine_y,
    output logic       o_sine_daynight,
    input  logic [5:0] i_sine_rgb,
    output logic [5:0] o_pixel_rgb,
    output logic [5:0] o_phase
);

    typedef enum logic {
        ST_RUN,
        ST_PAUSED
    } state_t;

    localparam logic [9:0] Y_TOP_V = 10'(Y_TOP);
    localparam logic [9:0] WIN_H   = 10'(22 << SCALE_LOG2);
    localparam logic [9:0] DN_LAST = 10'(DN_FRAMES - 1);

    state_t     r_state;
    logic [5:0] r_phase;
    logic [1:0] r_speed_q;
    logic       r_step_pend;
    logic [9:0] r_dn_cnt;
    logic       r_daynight;
    logic       r_seen_frame;

    logic [5:0] r_sine_x;
    logic [4:0] r_sine_y;
    logic       r_de_d;
    logic       r_in_win_d;
    logic [5:0] r_pixel;

    logic [1:0] w_speed_now;
    logic [1:0] w_inc;
    logic [5:0] w_phase_next;
    logic [5:0] w_hcell;
    logic [9:0] w_rel;
    logic       w_in_win;
    logic [4:0] w_ycell;

    // Phase increment for this cycle; non-zero only on a frame_start edge.
    always_comb begin
        w_inc       = 2'd0;
        w_speed_now = i_frame_start ? i_speed : r_speed_q;
        if (i_frame_start) begin
            if (!i_pause) begin
                w_inc = w_speed_now;
            end else if (r_state == ST_PAUSED && (r_step_pend || i_step)) begin
                w_inc = 2'd1;
            end
        end
    end

    assign w_phase_next = r_phase + {4'b0000, w_inc};

    assign w_hcell  = 6'(i_hpos >> SCALE_LOG2);
    assign w_rel    = i_vpos - Y_TOP_V;
    assign w_in_win = (i_vpos >= Y_TOP_V) && (w_rel < WIN_H);
    assign w_ycell  = 5'(w_rel >> SCALE_LOG2);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_phase      <= 6'd0;
            r_speed_q    <= 2'd0;
            r_step_pend  <= 1'b0;
            r_dn_cnt     <= 10'd0;
            r_daynight   <= 1'b0;
            r_seen_frame <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            if (i_frame_start) begin
                r_speed_q    <= i_speed;
                r_seen_frame <= 1'b1;
                r_step_pend  <= 1'b0;
                if (r_dn_cnt == DN_LAST) begin
                    r_dn_cnt   <= 10'd0;
                    r_daynight <= ~r_daynight;
                end else begin
                    r_dn_cnt <= r_dn_cnt + 10'd1;
                end
                case (r_state)
                    ST_RUN:    if (i_pause)  r_state <= ST_PAUSED;
                    ST_PAUSED: if (!i_pause) r_state <= ST_RUN;
                    default:   r_state <= ST_RUN;
                endcase
            end else if (r_state == ST_PAUSED) begin
                // Steps coalesce until the next frame boundary consumes them.
                r_step_pend <= r_step_pend | i_step;
            end else begin
                r_step_pend <= 1'b0;
            end
        end
    end

    // Display enable is held low until the first frame after reset so the
    // output stays black rather than showing a partial frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sine_x   <= 6'd0;
            r_sine_y   <= 5'd0;
            r_de_d     <= 1'b0;
            r_in_win_d <= 1'b0;
            r_pixel    <= 6'd0;
        end else begin
            r_sine_x   <= w_hcell + w_phase_next;
            r_sine_y   <= w_in_win ? w_ycell : 5'd0;
            r_de_d     <= i_display_on & (r_seen_frame | i_frame_start);
            r_in_win_d <= w_in_win;
            if (!r_de_d) begin
                r_pixel <= 6'd0;
            end else if (r_in_win_d) begin
                r_pixel <= i_sine_rgb;
            end else begin
                r_pixel <= {6{r_daynight}};
            end
        end
    end

    assign o_sine_x        = r_sine_x;
    assign o_sine_y        = r_sine_y;
    assign o_sine_daynight = r_daynight;
    assign o_pixel_rgb     = r_pixel;
    assign o_phase         = r_phase;

endmodule
